ob_mk_ptable: RTL and testbench
===============================

// Module: ob_mk_ptable
// PURPOSE
// - Parametrised successor to the single-side resting-order table: holds up to N resting orders for one book side.
// - Orders are kept price-sorted (best at slot 0), FIFO among equal prices, instead of append-only.
// - Supports tail/sorted insert, head pop, head quantity amend (partial fill), and cancel-by-UID.
// - Sits between the order-book FSM (matching engine) and per-side status (full/empty/depth/quantity).
// PARAMETERS
// - N          16  table depth in entries (>= 2)
// - IS_BID     1   1: best = highest price (bid side); 0: best = lowest price (ask side)
// - CNT_W      $clog2(N+1)  occupancy count width (derived, not overridden)
// PORTS
// - clk              in   1      clock
// - rst_n            in   1      asynchronous active-low reset
// - insert           in   1      insert order insert_tbl at its sorted position
// - insert_tbl       in   table_t  order to insert (uid, price, quantity)
// - head_pop         in   1      remove the slot-0 entry
// - head_amend       in   1      overwrite slot-0 quantity with head_amend_qty
// - head_amend_qty   in   quantity_t  new slot-0 quantity
// - cancel           in   1      search for cancel_uid and remove it on a hit
// - cancel_uid       in   uid_t  UID to cancel
// - head_vld_r       out  1      slot 0 is occupied
// - head_r           out  table_t  slot-0 contents (0 when !head_vld_r)
// - cancel_hit_r     out  1      1-cycle pulse: previous cycle's cancel hit
// - cancel_miss_r    out  1      1-cycle pulse: previous cycle's cancel missed
// - cancel_tbl_r     out  table_t  removed entry on a hit (held until the next cancel)
// - reject_r         out  1      1-cycle pulse: previous cycle's op was dropped (see BEHAVIOUR)
// - full_r / empty_r out  1      occupancy == N / occupancy == 0
// - count_r          out  CNT_W  occupancy
// - quantity_r       out  accum_quantity_t  sum of quantities of all valid entries
// BEHAVIOUR
// - Reset (async assert, sync deassert):
//   - all slot valids = 0; empty_r = 1; every other output = 0.
// - Arbitration: exactly one op is accepted per cycle.
//   - Priority is head_pop > head_amend > cancel > insert.
//   - Every lower-priority op asserted in the same cycle is dropped and reject_r pulses.
// - All state and outputs update on the clk edge after the accepted op (latency 1 cycle).
// - insert:
//   - Position p = first valid slot whose price is strictly worse than insert_tbl.price (IS_BID-aware).
//   - If no such slot exists, p = count.
//   - Slots p..count-1 shift toward N-1; the new entry loads p.
//   - If full_r: dropped, reject_r pulses, and state is unchanged (no eviction).
// - head_pop:
//   - All slots shift toward 0; slot N-1 becomes invalid.
//   - If empty_r: no state change, reject_r pulses.
// - head_amend:
//   - Slot-0 quantity replaced with head_amend_qty.
//   - If head_amend_qty == 0, it behaves exactly as head_pop.
//   - If empty_r: reject_r pulses.
// - cancel:
//   - Associative compare of uid over valid slots. UIDs are unique; on multiple hits the lowest index wins.
//   - Hit at k: slots k+1.. shift toward 0, cancel_tbl_r captures slot k, cancel_hit_r pulses.
//   - Miss: cancel_miss_r pulses; no state change.
// - quantity_r:
//   - insert adds insert_tbl.quantity.
//   - pop/cancel subtracts the removed entry's quantity.
//   - amend adds (new - old) in two's-complement within accum_quantity_t.
//   - accum_quantity_t is quantity_t width + $clog2(N): no overflow is possible.
// - count_r: +1 on accepted insert; -1 on accepted pop, zero-amend, or cancel hit.
//   full_r and empty_r derive from the next-state count.
// - Invariants (assert):
//   - valids are contiguous from slot 0.
//   - adjacent valid slots are non-worse in price order.
//   - quantity_r == sum of valid quantities.
// STRUCTURE
// - ob_pkg: table_t {uid, price, quantity}, uid_t, price_t, quantity_t, accum_quantity_t, and
//   function ob_pkg::price_better(a, b, is_bid).
// - Sub-module ob_mk_ptable_pos: combinational N-wide "first worse slot" locator,
//   returning a one-hot position plus a thermometer shift mask.
//   Reused for the cancel-hit mask (input = hit vector).
// - Storage: N slots, each a valid flop (async reset) plus a data register (no reset).
//   Per-slot next-state mux selects: hold / from i-1 / from i+1 / load insert / amend quantity.
// TESTING
// - Bid, N=4: insert prices 100,102,101,102 (uids 1-4)
//   -> slot order uids 2,4,3,1; head_r.price=102; count_r=4; full_r=1.
// - Full table: insert + head_pop same cycle -> pop wins, reject_r=1, count_r=3, uid 2 removed.
// - Ask, N=8: insert qty 5,7,9; head_amend_qty=2 -> quantity_r=18.
//   Then head_amend_qty=0 -> entry removed, quantity_r=16, count_r=2.
// - Cancel middle uid 3 of uids {2,4,3,1} -> cancel_hit_r=1, cancel_tbl_r.uid=3, order 2,4,1.
//   Cancel uid 9 -> cancel_miss_r=1, no change.
// - Empty table: head_pop -> reject_r=1, empty_r stays 1.
//   Insert one order, then pop -> empty_r=1, quantity_r=0.
// - rst_n asserted mid-burst of inserts -> next sampled outputs all 0, empty_r=1 asynchronously.
//   The first insert after release lands in slot 0.

Source files
------------

// File: rtl/ob_pkg.sv
// Shared order-book types for the resting-order table.
// Price order helper is IS_BID-aware.
package ob_pkg;

  localparam int UID_W   = 8;
  localparam int PRICE_W = 16;
  localparam int QTY_W   = 16;

  typedef logic [UID_W-1:0]   uid_t;
  typedef logic [PRICE_W-1:0] price_t;
  typedef logic [QTY_W-1:0]   quantity_t;

  typedef struct packed {
    uid_t      uid;
    price_t    price;
    quantity_t quantity;
  } table_t;

  // a is strictly better than b on this side
  function automatic logic price_better(
    input price_t a,
    input price_t b,
    input bit     is_bid
  );
    return is_bid ? (a > b) : (a < b);
  endfunction

endpackage

// File: rtl/ob_mk_ptable_if.sv
// Command/status bundle between matching FSM and one book side.
// master = matching engine, slave = table.
interface ob_mk_ptable_if
  import ob_pkg::*;
#(
  parameter int N = 16
) ();

  localparam int CNT_W = $clog2(N + 1);
  localparam int ACC_W = QTY_W + $clog2(N);

  typedef logic [ACC_W-1:0] accum_quantity_t;

  logic            insert;
  table_t          insert_tbl;
  logic            head_pop;
  logic            head_amend;
  quantity_t       head_amend_qty;
  logic            cancel;
  uid_t            cancel_uid;

  logic            head_vld_r;
  table_t          head_r;
  logic            cancel_hit_r;
  logic            cancel_miss_r;
  table_t          cancel_tbl_r;
  logic            reject_r;
  logic            full_r;
  logic            empty_r;
  logic [CNT_W-1:0] count_r;
  accum_quantity_t quantity_r;

  modport master (
    output insert, insert_tbl,
    output head_pop, head_amend,
    output head_amend_qty,
    output cancel, cancel_uid,
    input  head_vld_r, head_r,
    input  cancel_hit_r, cancel_miss_r,
    input  cancel_tbl_r, reject_r,
    input  full_r, empty_r,
    input  count_r, quantity_r
  );

  modport slave (
    input  insert, insert_tbl,
    input  head_pop, head_amend,
    input  head_amend_qty,
    input  cancel, cancel_uid,
    output head_vld_r, head_r,
    output cancel_hit_r, cancel_miss_r,
    output cancel_tbl_r, reject_r,
    output full_r, empty_r,
    output count_r, quantity_r
  );

endinterface

// File: rtl/ob_mk_ptable_pos.sv
// First-set-bit locator: one-hot position plus
// thermometer mask covering that slot and all above it.
module ob_mk_ptable_pos #(
  parameter int N = 16
) (
  input  logic [N-1:0] hit,
  output logic [N-1:0] onehot,
  output logic [N-1:0] therm,
  output logic         any
);

  logic seen;

  // scan from slot 0, latch once the first hit is seen
  always_comb begin
    seen   = 1'b0;
    onehot = '0;
    therm  = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = hit[i] & ~seen;
      seen      = seen | hit[i];
      therm[i]  = seen;
    end
  end

  assign any = therm[N-1];

endmodule

// File: rtl/ob_mk_ptable.sv
// Price-sorted resting-order table for one book side.
// Best at slot 0, FIFO among equal prices.
module ob_mk_ptable
  import ob_pkg::*;
#(
  parameter int N      = 16,
  parameter bit IS_BID = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  ob_mk_ptable_if.slave bus
);

  localparam int CNT_W = $clog2(N + 1);
  localparam int ACC_W = QTY_W + $clog2(N);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [ACC_W-1:0] accum_quantity_t;

  logic [N-1:0]    vld_q, vld_d;
  table_t          slot_q [N];
  table_t          slot_d [N];
  cnt_t            count_q, count_d;
  accum_quantity_t qty_q, qty_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            rej_q, rej_d;
  logic            hit_q, hit_d;
  logic            miss_q, miss_d;
  table_t          ctbl_q, ctbl_d;

  logic pop_req, amd_req;
  logic cxl_req, ins_req;
  logic lost, amd_zero;
  logic do_pop, do_amd;
  logic do_cxl, do_ins;

  logic [N-1:0] ins_hit, cxl_hit;
  logic [N-1:0] i_oh, i_th;
  logic [N-1:0] c_oh, c_th;
  logic         i_any, c_any;

  logic [N-1:0] up_v, dn_v;
  table_t       up_s [N];
  table_t       dn_s [N];
  logic [N-1:0] up_m, dn_m;
  logic [N-1:0] ld_m, am_m;
  table_t       c_sel;

  accum_quantity_t qsum;

  // fixed priority: pop > amend > cancel > insert
  always_comb begin
    pop_req = bus.head_pop;
    amd_req = bus.head_amend
            & ~bus.head_pop;
    cxl_req = bus.cancel
            & ~bus.head_pop
            & ~bus.head_amend;
    ins_req = bus.insert
            & ~bus.head_pop
            & ~bus.head_amend
            & ~bus.cancel;
    lost    = (bus.insert & ~ins_req)
            | (bus.cancel & ~cxl_req)
            | (bus.head_amend & ~amd_req);
    amd_zero = bus.head_amend_qty == '0;
    do_pop  = (pop_req | (amd_req & amd_zero))
            & ~empty_q;
    do_amd  = amd_req & ~amd_zero & ~empty_q;
    do_cxl  = cxl_req & c_any;
    do_ins  = ins_req & i_any & ~full_q;
  end

  // insert hits the first invalid or worse slot
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ins_hit[i] = ~vld_q[i]
                 | price_better(
                     bus.insert_tbl.price,
                     slot_q[i].price,
                     IS_BID);
      cxl_hit[i] = vld_q[i]
                 & (slot_q[i].uid == bus.cancel_uid);
    end
  end

  ob_mk_ptable_pos #(.N(N)) u_ins_pos (
    .hit    (ins_hit),
    .onehot (i_oh),
    .therm  (i_th),
    .any    (i_any)
  );

  ob_mk_ptable_pos #(.N(N)) u_cxl_pos (
    .hit    (cxl_hit),
    .onehot (c_oh),
    .therm  (c_th),
    .any    (c_any)
  );

  // neighbour taps for the shift network
  always_comb begin
    for (int i = 0; i < N - 1; i++) begin
      up_v[i] = vld_q[i+1];
      up_s[i] = slot_q[i+1];
    end
    up_v[N-1] = 1'b0;
    up_s[N-1] = slot_q[N-1];
    dn_v[0]   = 1'b1;
    dn_s[0]   = bus.insert_tbl;
    for (int i = 1; i < N; i++) begin
      dn_v[i] = vld_q[i-1];
      dn_s[i] = slot_q[i-1];
    end
  end

  // per-slot move selects
  always_comb begin
    up_m = {N{do_pop}} | ({N{do_cxl}} & c_th);
    dn_m = {N{do_ins}} & i_th & ~i_oh;
    ld_m = {N{do_ins}} & i_oh;
    am_m = '0;
    am_m[0] = do_amd;
  end

  // per-slot next state: hold/up/down/load/amend
  always_comb begin
    for (int i = 0; i < N; i++) begin
      vld_d[i]  = vld_q[i];
      slot_d[i] = slot_q[i];
      unique case (1'b1)
        up_m[i]: begin
          vld_d[i]  = up_v[i];
          slot_d[i] = up_s[i];
        end
        dn_m[i]: begin
          vld_d[i]  = dn_v[i];
          slot_d[i] = dn_s[i];
        end
        ld_m[i]: begin
          vld_d[i]  = 1'b1;
          slot_d[i] = bus.insert_tbl;
        end
        am_m[i]: begin
          slot_d[i].quantity = bus.head_amend_qty;
        end
        default: ;
      endcase
    end
  end

  // cancel victim
  always_comb begin
    c_sel = '0;
    for (int i = 0; i < N; i++)
      if (c_oh[i]) c_sel = slot_q[i];
  end

  // occupancy, quantity and status pulses
  always_comb begin
    count_d = count_q;
    qty_d   = qty_q;
    ctbl_d  = ctbl_q;
    unique case (1'b1)
      do_ins: begin
        count_d = count_q + cnt_t'(1);
        qty_d   = qty_q
                + ACC_W'(bus.insert_tbl.quantity);
      end
      do_pop: begin
        count_d = count_q - cnt_t'(1);
        qty_d   = qty_q
                - ACC_W'(slot_q[0].quantity);
      end
      do_cxl: begin
        count_d = count_q - cnt_t'(1);
        qty_d   = qty_q - ACC_W'(c_sel.quantity);
        ctbl_d  = c_sel;
      end
      do_amd: begin
        qty_d = qty_q
              + ACC_W'(bus.head_amend_qty)
              - ACC_W'(slot_q[0].quantity);
      end
      default: ;
    endcase
    full_d  = count_d == cnt_t'(N);
    empty_d = count_d == '0;
    rej_d   = lost
            | (pop_req & empty_q)
            | (amd_req & empty_q)
            | (ins_req & full_q);
    hit_d   = do_cxl;
    miss_d  = cxl_req & ~c_any;
  end

  // control state, async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      count_q <= '0;
      qty_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      rej_q   <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      ctbl_q  <= '0;
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
      qty_q   <= qty_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      rej_q   <= rej_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      ctbl_q  <= ctbl_d;
    end
  end

  // slot payload, qualified by vld_q
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  assign bus.head_vld_r    = vld_q[0];
  assign bus.head_r        = vld_q[0]
                           ? slot_q[0] : '0;
  assign bus.cancel_hit_r  = hit_q;
  assign bus.cancel_miss_r = miss_q;
  assign bus.cancel_tbl_r  = ctbl_q;
  assign bus.reject_r      = rej_q;
  assign bus.full_r        = full_q;
  assign bus.empty_r       = empty_q;
  assign bus.count_r       = count_q;
  assign bus.quantity_r    = qty_q;

  // reference sum for the quantity invariant
  always_comb begin
    qsum = '0;
    for (int i = 0; i < N; i++)
      if (vld_q[i])
        qsum = qsum
             + ACC_W'(slot_q[i].quantity);
  end

  a_contig: assert property (
    @(posedge clk) disable iff (!rst_n)
    ((vld_q >> 1) & ~vld_q) == '0);

  a_qty: assert property (
    @(posedge clk) disable iff (!rst_n)
    qty_q == qsum);

  for (genvar g = 0; g < N - 1; g++) begin : g_ord
    a_ord: assert property (
      @(posedge clk) disable iff (!rst_n)
      vld_q[g+1] |-> !price_better(
        slot_q[g+1].price,
        slot_q[g].price,
        IS_BID));
  end

endmodule

// File: tb/tb_ob_mk_ptable.sv
// Directed bench: bid N=4 vector table plus
// ask N=8 and reset sequences.
module tb_ob_mk_ptable;
  import ob_pkg::*;

  localparam logic [3:0] OI = 4'b1000;
  localparam logic [3:0] OP = 4'b0100;
  localparam logic [3:0] OA = 4'b0010;
  localparam logic [3:0] OC = 4'b0001;

  localparam logic [4:0] FF = 5'b10000;
  localparam logic [4:0] FE = 5'b01000;
  localparam logic [4:0] FR = 5'b00100;
  localparam logic [4:0] FH = 5'b00010;
  localparam logic [4:0] FM = 5'b00001;

  typedef struct {
    logic [3:0] op;
    int         u, p, q;
    int         hu, hp, hq;
    int         cnt;
    logic [4:0] fl;
    int         qty, ctu;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vec_t vt [19];

  ob_mk_ptable_if #(.N(4)) if_b ();
  ob_mk_ptable_if #(.N(8)) if_a ();

  ob_mk_ptable #(.N(4), .IS_BID(1'b1)) u_bid (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  ob_mk_ptable #(.N(8), .IS_BID(1'b0)) u_ask (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic set_ops(
    input bit         ask,
    input logic [3:0] op,
    input int         u,
    input int         p,
    input int         q
  );
    table_t t;
    t.uid      = uid_t'(u);
    t.price    = price_t'(p);
    t.quantity = quantity_t'(q);
    if (ask) begin
      if_a.insert         = op[3];
      if_a.insert_tbl     = t;
      if_a.head_pop       = op[2];
      if_a.head_amend     = op[1];
      if_a.head_amend_qty = quantity_t'(q);
      if_a.cancel         = op[0];
      if_a.cancel_uid     = uid_t'(u);
    end else begin
      if_b.insert         = op[3];
      if_b.insert_tbl     = t;
      if_b.head_pop       = op[2];
      if_b.head_amend     = op[1];
      if_b.head_amend_qty = quantity_t'(q);
      if_b.cancel         = op[0];
      if_b.cancel_uid     = uid_t'(u);
    end
  endtask

  task automatic step(
    input bit         ask,
    input logic [3:0] op,
    input int         u,
    input int         p,
    input int         q
  );
    @(negedge clk);
    set_ops(ask, op, u, p, q);
    @(posedge clk);
    #1;
    set_ops(ask, 4'b0000, 0, 0, 0);
  endtask

  task automatic run_vec(input int k);
    vec_t  v;
    string s;
    v = vt[k];
    step(1'b0, v.op, v.u, v.p, v.q);
    s = $sformatf("v%0d", k);
    chk({s, ".hv"}, 64'(if_b.head_vld_r),
        64'(v.hu != 0));
    chk({s, ".huid"}, 64'(if_b.head_r.uid),
        64'(v.hu));
    chk({s, ".hprice"},
        64'(if_b.head_r.price), 64'(v.hp));
    chk({s, ".hqty"},
        64'(if_b.head_r.quantity), 64'(v.hq));
    chk({s, ".count"}, 64'(if_b.count_r),
        64'(v.cnt));
    chk({s, ".full"}, 64'(if_b.full_r),
        64'(v.fl[4]));
    chk({s, ".empty"}, 64'(if_b.empty_r),
        64'(v.fl[3]));
    chk({s, ".reject"}, 64'(if_b.reject_r),
        64'(v.fl[2]));
    chk({s, ".hit"}, 64'(if_b.cancel_hit_r),
        64'(v.fl[1]));
    chk({s, ".miss"}, 64'(if_b.cancel_miss_r),
        64'(v.fl[0]));
    chk({s, ".qty"}, 64'(if_b.quantity_r),
        64'(v.qty));
    if (v.fl[1])
      chk({s, ".ctuid"},
          64'(if_b.cancel_tbl_r.uid),
          64'(v.ctu));
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    checks   = 0;
    failures = 0;
    set_ops(1'b0, 4'b0000, 0, 0, 0);
    set_ops(1'b1, 4'b0000, 0, 0, 0);

    // op, u, p, q, hu, hp, hq, cnt, flags, qty, ctu
    vt[0]  = '{4'b0, 0, 0, 0,
               0, 0, 0, 0, FE, 0, 0};
    vt[1]  = '{OI, 1, 100, 10,
               1, 100, 10, 1, 5'b0, 10, 0};
    vt[2]  = '{OI, 2, 102, 20,
               2, 102, 20, 2, 5'b0, 30, 0};
    vt[3]  = '{OI, 3, 101, 30,
               2, 102, 20, 3, 5'b0, 60, 0};
    vt[4]  = '{OI, 4, 102, 40,
               2, 102, 20, 4, FF, 100, 0};
    vt[5]  = '{OC, 3, 0, 0,
               2, 102, 20, 3, FH, 70, 3};
    vt[6]  = '{OI, 5, 99, 50,
               2, 102, 20, 4, FF, 120, 0};
    vt[7]  = '{OI | OP, 6, 200, 60,
               4, 102, 40, 3, FR, 100, 0};
    vt[8]  = '{OC, 9, 0, 0,
               4, 102, 40, 3, FM, 100, 0};
    vt[9]  = '{OI, 7, 101, 5,
               4, 102, 40, 4, FF, 105, 0};
    vt[10] = '{OI, 8, 150, 1,
               4, 102, 40, 4, FF | FR, 105, 0};
    vt[11] = '{OA | OC, 1, 0, 3,
               4, 102, 3, 4, FF | FR, 68, 0};
    vt[12] = '{OA, 0, 0, 0,
               7, 101, 5, 3, 5'b0, 65, 0};
    vt[13] = '{OP, 0, 0, 0,
               1, 100, 10, 2, 5'b0, 60, 0};
    vt[14] = '{OP, 0, 0, 0,
               5, 99, 50, 1, 5'b0, 50, 0};
    vt[15] = '{OP, 0, 0, 0,
               0, 0, 0, 0, FE, 0, 0};
    vt[16] = '{OP, 0, 0, 0,
               0, 0, 0, 0, FE | FR, 0, 0};
    vt[17] = '{OA, 0, 0, 7,
               0, 0, 0, 0, FE | FR, 0, 0};
    vt[18] = '{OC, 1, 0, 0,
               0, 0, 0, 0, FE | FM, 0, 0};

    #12;
    chk("rst.empty", 64'(if_b.empty_r), 64'(1));
    chk("rst.count", 64'(if_b.count_r), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 19; k++) run_vec(k);

    // ask side: amend, zero-amend, FIFO ties
    step(1'b1, OI, 1, 50, 5);
    step(1'b1, OI, 2, 51, 7);
    step(1'b1, OI, 3, 52, 9);
    chk("ask.qty3", 64'(if_a.quantity_r),
        64'(21));
    step(1'b1, OA, 0, 0, 2);
    chk("ask.amd.qty", 64'(if_a.quantity_r),
        64'(18));
    chk("ask.amd.hq",
        64'(if_a.head_r.quantity), 64'(2));
    step(1'b1, OA, 0, 0, 0);
    chk("ask.amd0.qty", 64'(if_a.quantity_r),
        64'(16));
    chk("ask.amd0.cnt", 64'(if_a.count_r),
        64'(2));
    chk("ask.amd0.huid",
        64'(if_a.head_r.uid), 64'(2));
    step(1'b1, OI, 4, 51, 1);
    chk("ask.tie.huid", 64'(if_a.head_r.uid),
        64'(2));
    step(1'b1, OI, 5, 10, 3);
    chk("ask.best.huid",
        64'(if_a.head_r.uid), 64'(5));
    step(1'b1, OP, 0, 0, 0);
    chk("ask.pop1.huid",
        64'(if_a.head_r.uid), 64'(2));
    step(1'b1, OP, 0, 0, 0);
    chk("ask.fifo.huid",
        64'(if_a.head_r.uid), 64'(4));
    chk("ask.end.qty", 64'(if_a.quantity_r),
        64'(10));
    chk("ask.end.cnt", 64'(if_a.count_r),
        64'(2));

    // reset asserted mid insert burst
    step(1'b0, OI, 1, 100, 1);
    @(negedge clk);
    set_ops(1'b0, OI, 2, 101, 2);
    @(posedge clk);
    #1;
    chk("burst.cnt", 64'(if_b.count_r), 64'(2));
    set_ops(1'b0, OI, 3, 102, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.empty", 64'(if_b.empty_r),
        64'(1));
    chk("arst.cnt", 64'(if_b.count_r), 64'(0));
    chk("arst.hv", 64'(if_b.head_vld_r),
        64'(0));
    chk("arst.head", 64'(if_b.head_r), 64'(0));
    chk("arst.qty", 64'(if_b.quantity_r),
        64'(0));
    chk("arst.ask.empty", 64'(if_a.empty_r),
        64'(1));
    @(negedge clk);
    set_ops(1'b0, 4'b0000, 0, 0, 0);
    rst_n = 1'b1;
    step(1'b0, OI, 9, 77, 4);
    chk("post.huid", 64'(if_b.head_r.uid),
        64'(9));
    chk("post.cnt", 64'(if_b.count_r), 64'(1));
    chk("post.qty", 64'(if_b.quantity_r),
        64'(4));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
